pc_update_unit: RTL and testbench

- Sequential program-counter register at the consuming end of the next-PC path.
- Holds the current PC and produces PC+STEP for the fetch/branch datapath.
- Selects and latches the next PC each clock: sequential, branch, jump or register-jump.
- Tracks run/halt/fault state, and counts committed PC updates for the single-cycle CPU.

---
 rtl/pc_update_unit.sv | 61 ++++++
 tb/tb_pc_update_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// pc_update_unit: registered program counter with next-PC select, run/halt/fault tracking and commit counter
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STEP     = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branchOffset,
  input  logic [25:0] jumpTarget,
  input  logic [31:0] regTarget,
  input  logic        halt,
  output logic [31:0] currentPC,
  output logic [31:0] pcPlus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] faultPC,
  output logic [31:0] commitCount
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  state_t      state;
  logic [31:0] candidate;
  logic        misaligned;
  assign pcPlus4 = currentPC + 32'(STEP);
  always_comb begin
    candidate = PCSrc == 2'b00 ? pcPlus4 :
                PCSrc == 2'b01 ? pcPlus4 + (branchOffset << 2) :
                PCSrc == 2'b10 ? {pcPlus4[31:28], jumpTarget, 2'b00} :
                                 regTarget;
    misaligned = |candidate[1:0];
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= BOOT;
      currentPC   <= RESET_PC;
      halted      <= 1'b0;
      fault       <= 1'b0;
      faultPC     <= 32'h0;
      commitCount <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (PCWre && misaligned) begin
            state   <= FAULT;
            fault   <= 1'b1;
            faultPC <= currentPC;
          end else if (PCWre) begin
            currentPC   <= candidate;
            commitCount <= commitCount + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: directed vectors checked each cycle against a behavioural PC model plus literal expectations
module tb_pc_update_unit;
  logic        CLK = 1'b0;
  logic        Reset, PCWre, halt;
  logic [1:0]  PCSrc;
  logic [31:0] branchOffset, regTarget;
  logic [25:0] jumpTarget;
  logic [31:0] currentPC, pcPlus4, faultPC, commitCount;
  logic        halted, fault;
  int          errors = 0, checks = 0;
  bit          chk_on = 1'b0;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  int          m_mode;
  logic [31:0] m_pc, m_cnt, m_fpc, m_next;

  pc_update_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
    .branchOffset(branchOffset), .jumpTarget(jumpTarget), .regTarget(regTarget),
    .halt(halt), .currentPC(currentPC), .pcPlus4(pcPlus4), .halted(halted),
    .fault(fault), .faultPC(faultPC), .commitCount(commitCount)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (Reset) begin
      m_mode = M_BOOT; m_pc = 32'h0; m_cnt = 32'h0; m_fpc = 32'h0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      case (PCSrc)
        2'd0: m_next = m_pc + 4;
        2'd1: m_next = m_pc + 4 + branchOffset * 4;
        2'd2: m_next = ((m_pc + 4) & 32'hF000_0000) | (32'(jumpTarget) * 4);
        default: m_next = regTarget;
      endcase
      if (halt) m_mode = M_HALT;
      else if (PCWre && (m_next % 4 != 0)) begin m_mode = M_FAULT; m_fpc = m_pc; end
      else if (PCWre) begin m_pc = m_next; m_cnt = m_cnt + 1; end
    end
  end

  always @(negedge CLK) if (chk_on) begin
    cmp("currentPC", currentPC, m_pc);
    cmp("pcPlus4", pcPlus4, m_pc + 32'd4);
    cmp("halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
    cmp("fault", {31'b0, fault}, {31'b0, m_mode == M_FAULT});
    cmp("faultPC", faultPC, m_fpc);
    cmp("commitCount", commitCount, m_cnt);
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] off,
                       input logic [25:0] jt, input logic [31:0] rt, input logic h);
    PCWre = we; PCSrc = src; branchOffset = off; jumpTarget = jt; regTarget = rt; halt = h;
    step();
  endtask

  initial begin
    Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'd0; branchOffset = 0; jumpTarget = 0; regTarget = 0; halt = 1'b0;
    step();
    chk_on = 1'b1;
    Reset = 1'b0;
    cmp("lit_reset_pc", currentPC, 32'h0);
    cmp("lit_reset_cnt", commitCount, 32'h0);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_boot_hold", currentPC, 32'h0);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_seq4", currentPC, 32'h4);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_seq8", currentPC, 32'h8);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_seqC", currentPC, 32'hC);
    cmp("lit_cnt3", commitCount, 32'd3);
    drive(1, 2'd0, 0, 0, 0, 0);
    drive(1, 2'd1, 32'hFFFF_FFFE, 0, 0, 0);
    cmp("lit_branch_back", currentPC, 32'h0C);
    drive(1, 2'd0, 0, 0, 0, 0);
    drive(1, 2'd1, 32'd3, 0, 0, 0);
    cmp("lit_branch_fwd", currentPC, 32'h20);
    drive(1, 2'd3, 0, 0, 32'h9000_0000, 0);
    drive(1, 2'd2, 0, 26'h0000040, 0, 0);
    cmp("lit_jump", currentPC, 32'h9000_0100);
    cmp("lit_cnt9", commitCount, 32'd9);
    drive(0, 2'd1, 32'h1234, 26'h3FF, 32'h42, 0);
    drive(0, 2'd3, 32'h5, 26'h1, 32'h100, 0);
    drive(0, 2'd2, 32'hFFFF_0000, 26'h2A, 32'h7, 0);
    cmp("lit_idle_pc", currentPC, 32'h9000_0100);
    cmp("lit_idle_cnt", commitCount, 32'd9);
    drive(1, 2'd3, 0, 0, 32'hFFFF_FFFC, 0);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_wrap", currentPC, 32'h0);
    drive(1, 2'd3, 0, 0, 32'h20, 0);
    drive(1, 2'd3, 0, 0, 32'h42, 0);
    cmp("lit_fault_pc", currentPC, 32'h20);
    cmp("lit_fault", {31'b0, fault}, 32'd1);
    cmp("lit_faultPC", faultPC, 32'h20);
    drive(1, 2'd0, 0, 0, 0, 0);
    drive(1, 2'd3, 0, 0, 32'h100, 1);
    cmp("lit_fault_sticky", currentPC, 32'h20);
    cmp("lit_fault_nohalt", {31'b0, halted}, 32'd0);
    Reset = 1'b1;
    drive(1, 2'd3, 0, 0, 32'h42, 1);
    Reset = 1'b0;
    cmp("lit_rst2_fault", {31'b0, fault}, 32'd0);
    drive(0, 2'd0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 1);
    cmp("lit_halt_pc", currentPC, 32'h4);
    cmp("lit_halted", {31'b0, halted}, 32'd1);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_halt_sticky", currentPC, 32'h4);
    Reset = 1'b1;
    drive(1, 2'd0, 0, 0, 0, 0);
    Reset = 1'b0;
    cmp("lit_rst3_pc", currentPC, 32'h0);
    cmp("lit_rst3_halted", {31'b0, halted}, 32'd0);
    cmp("lit_rst3_cnt", commitCount, 32'd0);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_boot2", currentPC, 32'h0);
    drive(1, 2'd0, 0, 0, 0, 0);
    cmp("lit_after_boot", currentPC, 32'h4);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
